// File: rtl/song_sequencer_pkg.sv
// Shared definitions for the song sequencer.
//   state_t          : sequencer state encoding
//   ROM field layout : {div_left, div_right, beats} within a 48-bit ROM word
//   END_MARKER       : beats value that terminates a song
//   VOL_STEP_DEFAULT : amplitude increment per volume level
package song_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_PLAY,
    S_PAUSE,
    S_END
  } state_t;

  localparam int NOTE_W  = 22;
  localparam int ROM_W   = 48;
  localparam int BEATS_W = 4;
  localparam int AMP_W   = 16;
  localparam int VOL_W   = 3;

  localparam int DIVL_MSB  = 47;
  localparam int DIVL_LSB  = 26;
  localparam int DIVR_MSB  = 25;
  localparam int DIVR_LSB  = 4;
  localparam int BEATS_MSB = 3;
  localparam int BEATS_LSB = 0;

  localparam logic [BEATS_W-1:0] END_MARKER       = '0;
  localparam logic [AMP_W-1:0]   VOL_STEP_DEFAULT = 16'h1000;

endpackage

// File: rtl/song_sequencer_if.sv
// Bundle of control, song-ROM and buzzer signals around the song sequencer.
//   master : player controls, piano keys and ROM read data; observes outputs
//   slave  : the sequencer; drives rom_addr, divisors, amplitudes, busy, done
interface song_sequencer_if #(
  parameter int ADDR_W = 8
);
  import song_seq_pkg::*;

  logic                play_pause;
  logic                stop;
  logic                loop_en;
  logic [VOL_W-1:0]    vol;
  logic                key_valid;
  logic [NOTE_W-1:0]   key_div;
  logic [ADDR_W-1:0]   rom_addr;
  logic [ROM_W-1:0]    rom_data;
  logic [NOTE_W-1:0]   note_div_left;
  logic [NOTE_W-1:0]   note_div_right;
  logic [AMP_W-1:0]    high;
  logic [AMP_W-1:0]    low;
  logic                busy;
  logic                done;

  modport master (
    output play_pause, stop, loop_en, vol, key_valid, key_div, rom_data,
    input  rom_addr, note_div_left, note_div_right, high, low, busy, done
  );

  modport slave (
    input  play_pause, stop, loop_en, vol, key_valid, key_div, rom_data,
    output rom_addr, note_div_left, note_div_right, high, low, busy, done
  );

endinterface

// File: rtl/song_sequencer_beat_timer.sv
// Beat timer: counts enabled cycles and emits a one-cycle tick on the last
// cycle of every BEAT_DIV-cycle beat.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : restart the beat at phase 0 (wins over enable)
//   enable     : advance the beat phase this cycle
//   tick       : high on the final enabled cycle of a beat
module beat_timer #(
  parameter int BEAT_DIV = 25000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int              CNT_W = $clog2(BEAT_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEAT_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = enable && !clear && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/song_sequencer.sv
// Song sequencer: walks a song ROM note by note and drives the two-channel
// buzzer divisors and amplitudes. A held piano key overrides both channels
// while the song keeps running underneath.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : song_sequencer_if.slave (controls, keys, ROM port, buzzer
//                divisors, high/low amplitude, busy, done)
module song_sequencer
  import song_seq_pkg::*;
#(
  parameter int               BEAT_DIV = 25000000,
  parameter int               ADDR_W   = 8,
  parameter logic [AMP_W-1:0] VOL_STEP = VOL_STEP_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  song_sequencer_if.slave  bus
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  state_t              state;
  logic [ADDR_W-1:0]   addr;
  logic [NOTE_W-1:0]   song_l;
  logic [NOTE_W-1:0]   song_r;
  logic [BEATS_W-1:0]  beats_left;
  logic [NOTE_W-1:0]   note_l;
  logic [NOTE_W-1:0]   note_r;
  logic                busy_q;
  logic                done_q;
  logic [AMP_W-1:0]    high_q;
  logic signed [AMP_W-1:0] low_q;

  logic [NOTE_W-1:0]  rom_divl;
  logic [NOTE_W-1:0]  rom_divr;
  logic [BEATS_W-1:0] rom_beats;
  logic               key_hit;
  logic               beat_tick;
  logic               timer_clear;
  logic               timer_en;

  function automatic logic [AMP_W-1:0] amp_high(input logic [VOL_W-1:0] v);
    logic [AMP_W+VOL_W-1:0] prod;
    prod = {{AMP_W{1'b0}}, v} * {{VOL_W{1'b0}}, VOL_STEP};
    return prod[AMP_W-1:0];
  endfunction

  function automatic logic signed [AMP_W-1:0] amp_neg(input logic [AMP_W-1:0] h);
    return -$signed(h);
  endfunction

  assign rom_divl  = bus.rom_data[DIVL_MSB:DIVL_LSB];
  assign rom_divr  = bus.rom_data[DIVR_MSB:DIVR_LSB];
  assign rom_beats = bus.rom_data[BEATS_MSB:BEATS_LSB];
  assign key_hit   = bus.key_valid && (bus.key_div != '0);

  // The beat phase restarts with every freshly loaded note and freezes in PAUSE.
  assign timer_clear = (state == S_LOAD);
  assign timer_en    = (state == S_PLAY);

  beat_timer #(
    .BEAT_DIV(BEAT_DIV)
  ) u_beat_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (timer_clear),
    .enable(timer_en),
    .tick  (beat_tick)
  );

  // Sequencer state and registered buzzer outputs. Divisors default to silence
  // each cycle; only branches that remain in (or enter) PLAY restore the song
  // note, and a held key overrides whatever the song chose.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      addr       <= '0;
      song_l     <= '0;
      song_r     <= '0;
      beats_left <= '0;
      note_l     <= '0;
      note_r     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      note_l <= '0;
      note_r <= '0;
      done_q <= 1'b0;
      if (bus.stop) begin
        state  <= S_IDLE;
        addr   <= '0;
        busy_q <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.play_pause) begin
              state  <= S_FETCH;
              addr   <= '0;
              busy_q <= 1'b1;
            end
          end
          S_FETCH: state <= S_LOAD;
          S_LOAD: begin
            song_l     <= rom_divl;
            song_r     <= rom_divr;
            beats_left <= rom_beats;
            if (rom_beats == END_MARKER) begin
              // An end marker at address 0 never loops: the song is empty.
              if (bus.loop_en && (addr != '0)) begin
                state <= S_FETCH;
                addr  <= '0;
              end else begin
                state  <= S_END;
                addr   <= '0;
                busy_q <= 1'b0;
                done_q <= 1'b1;
              end
            end else begin
              state  <= S_PLAY;
              note_l <= rom_divl;
              note_r <= rom_divr;
            end
          end
          S_PLAY: begin
            if (beat_tick && (beats_left == BEATS_W'(1))) begin
              if (addr != ADDR_MAX) begin
                state <= S_FETCH;
                addr  <= addr + 1'b1;
              end else if (bus.loop_en) begin
                state <= S_FETCH;
                addr  <= '0;
              end else begin
                state  <= S_END;
                addr   <= '0;
                busy_q <= 1'b0;
                done_q <= 1'b1;
              end
            end else begin
              if (beat_tick) begin
                beats_left <= beats_left - 1'b1;
              end
              if (bus.play_pause) begin
                state <= S_PAUSE;
              end else begin
                note_l <= song_l;
                note_r <= song_r;
              end
            end
          end
          S_PAUSE: begin
            if (bus.play_pause) begin
              state  <= S_PLAY;
              note_l <= song_l;
              note_r <= song_r;
            end
          end
          S_END: state <= S_IDLE;
          default: begin
            state  <= S_IDLE;
            addr   <= '0;
            busy_q <= 1'b0;
          end
        endcase
      end
      if (key_hit) begin
        note_l <= bus.key_div;
        note_r <= bus.key_div;
      end
    end
  end

  // Amplitude stage: one register after vol.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      high_q <= '0;
      low_q  <= '0;
    end else begin
      high_q <= amp_high(bus.vol);
      low_q  <= amp_neg(amp_high(bus.vol));
    end
  end

  assign bus.rom_addr       = addr;
  assign bus.note_div_left  = note_l;
  assign bus.note_div_right = note_r;
  assign bus.high           = high_q;
  assign bus.low            = low_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Testbench for song_sequencer (BEAT_DIV=4, ADDR_W=3). Expected behaviour is a
// per-cycle timeline built from the song rules (2 silent cycles per fetched
// entry, beats*BEAT_DIV sounding cycles per note, end/loop handling), with
// key override and amplitude applied from the inputs of the previous cycle.
module tb_song_sequencer;
  import song_seq_pkg::*;

  localparam int          BEAT_DIV = 4;
  localparam int          ADDR_W   = 3;
  localparam int          DEPTH    = 1 << ADDR_W;
  localparam logic [15:0] STEP     = 16'h1000;

  typedef struct packed {
    logic [21:0]       l;
    logic [21:0]       r;
    logic              busy;
    logic              done;
    logic              chk_addr;
    logic [ADDR_W-1:0] addr;
  } step_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [47:0] rom [DEPTH];
  logic [47:0] rom_q;
  step_t       tl[$];
  logic        kv;
  logic [21:0] kd;
  logic [2:0]  vv;

  always #5 clk = ~clk;

  song_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  song_sequencer #(
    .BEAT_DIV(BEAT_DIV),
    .ADDR_W  (ADDR_W),
    .VOL_STEP(STEP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Synchronous ROM: data valid one cycle after the address.
  always @(posedge clk) rom_q <= rom[bus.rom_addr];
  assign bus.rom_data = rom_q;

  initial begin
    #5ms;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [47:0] entry(input int l, input int r, input int b);
    return {22'(l), 22'(r), 4'(b)};
  endfunction

  function automatic step_t mk(input logic [21:0] l, input logic [21:0] r, input logic b,
                               input logic d, input logic c, input int a);
    step_t s;
    s.l = l; s.r = r; s.busy = b; s.done = d; s.chk_addr = c; s.addr = ADDR_W'(a);
    return s;
  endfunction

  function automatic logic [79:0] outs();
    return {2'b00, bus.note_div_left, bus.note_div_right, bus.busy, bus.done, bus.high, bus.low};
  endfunction

  function automatic logic [79:0] exp_vec(input logic [21:0] l, input logic [21:0] r,
                                          input logic b, input logic d, input int v);
    logic [15:0] h;
    logic [15:0] lo;
    h  = 16'((v * int'(STEP)) % 65536);
    lo = 16'((65536 - int'(h)) % 65536);
    return {2'b00, l, r, b, d, h, lo};
  endfunction

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_rom_a();
    rom[0] = entry(100, 200, 2);
    rom[1] = entry(300, 300, 1);
    rom[2] = entry(0, 0, 0);
    for (int a = 3; a < DEPTH; a++) rom[a] = entry(a * 11, a * 13, 1);
  endtask

  // Expected cycle-by-cycle outputs of a song started from IDLE, without keys.
  task automatic build_timeline(input logic loop, input int maxlen);
    int a;
    int b;
    logic [21:0] l;
    logic [21:0] r;
    tl.delete();
    a = 0;
    while (tl.size() < maxlen) begin
      tl.push_back(mk(0, 0, 1, 0, 1, a));
      tl.push_back(mk(0, 0, 1, 0, 0, a));
      b = int'(rom[a][3:0]);
      l = rom[a][47:26];
      r = rom[a][25:4];
      if (b == 0) begin
        if (loop && a != 0) begin
          a = 0;
          continue;
        end
        tl.push_back(mk(0, 0, 0, 1, 0, 0));
        tl.push_back(mk(0, 0, 0, 0, 1, 0));
        break;
      end
      for (int k = 0; k < b * BEAT_DIV; k++) tl.push_back(mk(l, r, 1, 0, 0, 0));
      if (a == DEPTH - 1) begin
        if (loop) a = 0;
        else begin
          tl.push_back(mk(0, 0, 0, 1, 0, 0));
          tl.push_back(mk(0, 0, 0, 0, 1, 0));
          break;
        end
      end else begin
        a++;
      end
    end
    while (tl.size() > maxlen) void'(tl.pop_back());
  endtask

  // Called at #1 after a clock edge with the DUT idle.
  task automatic run_song(input logic loop, input logic use_key, input int pause_at,
                          input int pause_len, input int maxlen, input logic do_stop,
                          input string tag);
    step_t e;
    logic [21:0] el;
    logic [21:0] er;
    build_timeline(loop, maxlen);
    if (pause_at > 0)
      for (int j = 0; j < pause_len; j++) tl.insert(pause_at, mk(0, 0, 1, 0, 0, 0));
    kv = 1'b0; kd = '0; vv = 3'($urandom_range(0, 7));
    bus.key_valid = kv; bus.key_div = kd; bus.vol = vv;
    bus.loop_en = loop;
    bus.play_pause = 1'b1;
    for (int i = 0; i < tl.size(); i++) begin
      @(posedge clk); #1;
      bus.play_pause = 1'b0;
      e  = tl[i];
      el = e.l;
      er = e.r;
      if (kv && kd != '0) begin
        el = kd;
        er = kd;
      end
      check($sformatf("%s_cyc%0d", tag, i + 1), outs(), exp_vec(el, er, e.busy, e.done, int'(vv)));
      if (e.chk_addr)
        check($sformatf("%s_addr%0d", tag, i + 1), 80'(bus.rom_addr), 80'(e.addr));
      if (pause_at > 0 && (i + 1 == pause_at || i + 1 == pause_at + pause_len))
        bus.play_pause = 1'b1;
      if (use_key && i != tl.size() - 1) begin
        kv = ($urandom_range(0, 3) == 0);
        kd = ($urandom_range(0, 4) == 0) ? 22'd0 : 22'($urandom_range(1, 4194303));
      end else begin
        kv = 1'b0;
        kd = '0;
      end
      vv = 3'($urandom_range(0, 7));
      bus.key_valid = kv; bus.key_div = kd; bus.vol = vv;
    end
    if (do_stop) begin
      bus.stop = 1'b1;
      bus.play_pause = 1'b1;
      @(posedge clk); #1;
      check({tag, "_stop"}, outs(), exp_vec(0, 0, 0, 0, int'(vv)));
      check({tag, "_stop_addr"}, 80'(bus.rom_addr), 80'(0));
      bus.stop = 1'b0;
      bus.play_pause = 1'b0;
      @(posedge clk); #1;
      check({tag, "_stop_idle"}, outs(), exp_vec(0, 0, 0, 0, int'(vv)));
    end
  endtask

  initial begin
    bus.play_pause = 1'b0;
    bus.stop       = 1'b0;
    bus.loop_en    = 1'b0;
    bus.vol        = 3'd5;
    bus.key_valid  = 1'b0;
    bus.key_div    = '0;
    for (int a = 0; a < DEPTH; a++) rom[a] = '0;

    // Reset holds every output at zero even with a nonzero volume.
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", outs(), exp_vec(0, 0, 0, 0, 0));
    check("reset_addr", 80'(bus.rom_addr), 80'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_amp", outs(), exp_vec(0, 0, 0, 0, 5));

    // Reference song, single pass: done on cycle 19.
    set_rom_a();
    run_song(1'b0, 1'b0, 0, 0, 1000, 1'b0, "songA");

    // Looping song, aborted mid-note by stop together with play_pause.
    run_song(1'b1, 1'b0, 0, 0, 60, 1'b1, "loopA");

    // Pause on the second note cycle for 10 cycles.
    run_song(1'b0, 1'b0, 4, 10, 1000, 1'b0, "pause");

    // Piano keys override the song without moving note boundaries.
    run_song(1'b0, 1'b1, 0, 0, 1000, 1'b0, "keys");

    // Empty song with looping enabled still ends.
    rom[0] = entry(5, 5, 0);
    run_song(1'b1, 1'b0, 0, 0, 100, 1'b0, "empty");

    // Random songs, end marker anywhere or absent (address wrap).
    for (int it = 0; it < 6; it++) begin
      int endpos;
      endpos = $urandom_range(0, DEPTH);
      for (int a = 0; a < DEPTH; a++)
        rom[a] = entry($urandom_range(1, 4194303), $urandom_range(1, 4194303),
                       (a == endpos) ? 0 : $urandom_range(1, 3));
      run_song(1'(it % 2), 1'b1, 0, 0, (it % 2 != 0) ? 150 : 2000, 1'(it % 2),
               $sformatf("rand%0d", it));
    end

    // Asynchronous reset in the middle of a note.
    set_rom_a();
    bus.loop_en = 1'b0;
    bus.vol = 3'd3;
    bus.play_pause = 1'b1;
    @(posedge clk); #1;
    bus.play_pause = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    check("mid_play", outs(), exp_vec(100, 200, 1, 0, 3));
    rst_n = 1'b0;
    #1;
    check("async_reset", outs(), exp_vec(0, 0, 0, 0, 0));
    check("async_reset_addr", 80'(bus.rom_addr), 80'(0));
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", outs(), exp_vec(0, 0, 0, 0, 0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("vol3", outs(), exp_vec(0, 0, 0, 0, 3));
    bus.vol = 3'd0;
    @(posedge clk); #1;
    check("vol0", outs(), exp_vec(0, 0, 0, 0, 0));
    bus.vol = 3'd7;
    @(posedge clk); #1;
    check("vol7", outs(), exp_vec(0, 0, 0, 0, 7));
    check("idle_after_reset_addr", 80'(bus.rom_addr), 80'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Drives the note-divisor and amplitude inputs of the two-channel buzzer square-wave generator.
- Steps through a song ROM one note entry at a time, holding each note for a programmed number of beats.
- Supports play/pause/stop, looping and 8-level volume.
- Arbitrates the buzzer between song playback and live piano-key presses; a key press always wins.

Parameters:
- BEAT_DIV, 25000000, clk cycles per beat (0.25 s at 100 MHz); must be >= 2.
- ADDR_W, 8, song ROM address width.
- VOL_STEP, 16'h1000, amplitude increment per volume level.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- play_pause  in  1  single-cycle pulse: start from IDLE, or toggle PLAY/PAUSE
- stop  in  1  single-cycle pulse: abort playback and return to address 0
- loop_en  in  1  level; restart at address 0 when the song ends
- vol  in  3  volume level 0..7
- key_valid  in  1  level; a piano key is held
- key_div  in  22  divisor of the held key
- rom_addr  out  ADDR_W  song ROM address
- rom_data  in  48  {div_left[47:26], div_right[25:4], beats[3:0]}; valid 1 cycle after rom_addr
- note_div_left  out  22  left-channel divisor to the buzzer; 0 = silent
- note_div_right  out  22  right-channel divisor to the buzzer; 0 = silent
- high  out  16  positive amplitude
- low  out  16  negative amplitude
- busy  out  1  high in FETCH/LOAD/PLAY/PAUSE
- done  out  1  one-cycle pulse when a non-looping song ends

Behaviour:
- Reset: state IDLE; rom_addr=0; note_div_left/right=0; high=low=0; busy=0; done=0; beat counter=0.
- All outputs are registered.
- States and transitions:
  - IDLE: play_pause -> FETCH at address 0.
  - FETCH: rom_addr is driven; the ROM read is in flight -> LOAD.
  - LOAD: capture rom_data. If beats==0 (end marker): with loop_en=1 and addr!=0 -> FETCH at addr 0; otherwise -> END. If beats!=0 -> PLAY, beat counter cleared.
  - PLAY: beat counter runs 0..BEAT_DIV-1; each wrap decrements the remaining beats. When the last beat expires: addr+1 -> FETCH. If addr==2^ADDR_W-1: wrap to 0 and -> FETCH when loop_en=1, else -> END.
  - PAUSE: beat counter and remaining beats frozen; play_pause -> PLAY, resuming the exact phase.
  - END: done=1 for this cycle only -> IDLE, addr 0.
- An end marker at address 0 always goes to END. This prevents an infinite fetch loop on an empty song.
- stop in any state -> IDLE next cycle, addr 0, song channels muted. stop and play_pause in the same cycle: stop wins.
- play_pause in FETCH/LOAD is ignored. play_pause in END is ignored.
- Latency:
  - play_pause in IDLE at cycle t: FETCH at t+1, LOAD at t+2, divisors valid at t+3.
  - Each note sounds for exactly beats*BEAT_DIV cycles.
  - The FETCH/LOAD gap (2 cycles) outputs divisor 0, giving a deliberate articulation gap.
- Song divisors are nonzero only in PLAY; they are 0 in IDLE, PAUSE, END, FETCH and LOAD.
- Key arbitration:
  - If key_valid=1 and key_div!=0: both note_div outputs = key_div on the next cycle, in every state.
  - The song state machine and beat timing keep running underneath the override.
  - On key release, the song divisors (or 0) return on the next cycle.
- Amplitude:
  - high = vol*VOL_STEP, unsigned product truncated to 16 bits.
  - low = two's-complement negation of high.
  - vol=0 gives high=low=0.
  - Registered; 1-cycle latency from a vol change.
- Reset mid-operation: immediate asynchronous return to reset values. No ROM access is pending after reset.

Decomposition:
- Package song_seq_pkg holds:
  - state encoding (IDLE, FETCH, LOAD, PLAY, PAUSE, END);
  - ROM field positions (DIVL_MSB/LSB, DIVR_MSB/LSB, BEATS_MSB/LSB);
  - the END_MARKER beats value (0);
  - the default VOL_STEP.
- One sub-module, beat_timer:
  - inputs: clear, enable;
  - output: one-cycle tick every BEAT_DIV enabled cycles;
  - clear has priority over enable.

Test Plan (BEAT_DIV=4, ADDR_W=3):
- ROM[0]={100,200,2}, ROM[1]={300,300,1}, ROM[2] beats=0, loop_en=0, pulse play_pause at t=0 -> divisors 100/200 for cycles 3..10; 0 for 11..12; 300/300 for 13..16; done pulse at cycle 19; then IDLE with busy=0.
- Same ROM, loop_en=1 -> after ROM[2], address returns to 0 and 100/200 reappears; done never asserts; ROM[0] beats=0 with loop_en=1 -> END and done within 3 cycles of start.
- Pulse play_pause 2 cycles into ROM[0] playback, wait 10 cycles, pulse again -> divisors 0 while paused; after resume the remaining 6 cycles of note 0 play, then the gap.
- key_valid=1, key_div=500 during a song note -> both divisors 500 one cycle later; release -> song divisor returns next cycle; note end timing unchanged versus a run without the key press.
- stop and play_pause asserted in the same cycle during PLAY -> IDLE next cycle, divisors 0, rom_addr 0.
- vol=3 -> high=16'h3000, low=16'hD000; vol=0 -> high=low=0; deassert rst_n mid-PLAY -> all outputs 0 asynchronously.
